shift_arbiter: RTL and testbench
================================

# shift_arbiter

Round-robin scheduler that shares one `right_shifter` datapath instance among `NUM_REQ` requesters, such as accumulator lanes needing scale alignment. It accepts at most one shift per cycle through per-requester valid/ready handshakes. The shift result is registered into a single-entry output stage with a valid/ready handshake and a requester ID tag. It sits between the accumulator lanes and the requantization/writeback path.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..16.
- `ID_W`, default 2: width of the requester ID; equals `$clog2(NUM_REQ)`.
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: reset. Synchronous, active-low.
- `req_valid`, input, `NUM_REQ`: bit i means requester i presents a shift.
- `req_data`, input, `NUM_REQ*32`: operand for requester i in bits [32i+31:32i].
- `req_shamt`, input, `NUM_REQ*6`: shift amount for requester i in bits [6i+5:6i].
- `req_ready`, output, `NUM_REQ`: bit i means requester i's transfer is accepted this cycle.
- `resp_valid`, output, 1: output register holds a result.
- `resp_data`, output, 32: registered shift result.
- `resp_id`, output, `ID_W`: index of the requester that produced `resp_data`.
- `resp_ready`, input, 1: consumer accepts the result.
- `op_count`, output, 16: number of accepted requests; wraps modulo 2^16.

## Operation
- Shifter function: result = `data << shamt[4:0]`, zero-filled. If `shamt[5]` is 1, the result is 32'h0.
- `can_accept = ~resp_valid | resp_ready`.
- Arbitration:
  - Combinational round-robin over `req_valid`.
  - Search starts at `(last_ptr+1) mod NUM_REQ` and takes the first asserted valid.
  - The result is a one-hot `grant`, or zero if no valids are asserted.
- `req_ready = grant & {NUM_REQ{can_accept}}`. At most one bit is set; `req_ready` may depend on `req_valid`.
- Transfer on requester i occurs when `req_valid[i] & req_ready[i]`.
- On a transfer:
  - The granted data/shamt is muxed into the shifter.
  - `resp_data` ← shifter result, `resp_id` ← i, `resp_valid` ← 1.
  - `last_ptr` ← i.
  - `op_count` ← `op_count + 1`.
- No transfer and `resp_ready & resp_valid`: `resp_valid` ← 0. `resp_data` and `resp_id` hold their values.
- No transfer and no output handshake: all state holds.
- `last_ptr` advances only on an accepted transfer. A grant that is blocked by `~can_accept` does not rotate priority.
- Requester rules: `req_valid[i]` must not depend on `req_ready[i]`. Data and shamt must stay stable while valid is high and not yet accepted. Dropping valid before acceptance is legal; the block does not latch unaccepted requests.
- Consumer rule: `resp_data` and `resp_id` are stable while `resp_valid & ~resp_ready`.

## Timing
- Latency: 1 cycle from accepted request to `resp_valid`.
- Throughput: 1 result per cycle while `resp_ready` is held high.
- Fairness: with all requesters valid and the output unblocked, grant order is 0,1,…,NUM_REQ-1,0,… Each requester waits at most NUM_REQ-1 accepted transfers.
- Simultaneous output pop and new accept: the new result overwrites the register in the same edge and `resp_valid` stays 1, with no bubble.
- Reset values (`rst_n` low at the edge):
  - `resp_valid`=0, `resp_data`=0, `resp_id`=0, `op_count`=0.
  - `last_ptr`=NUM_REQ-1, so requester 0 has first priority.
  - A result pending at reset is discarded.
  - `req_ready` is 0 during any cycle where `rst_n` is low.
- `op_count` wraps 16'hFFFF → 16'h0000 without flagging.

## Structure
- Shared package `nnacc_pkg`: `DATA_W=32` and `SHAMT_W=6`.
- Sub-module: the existing `right_shifter`, instantiated once with `data`, `shifter` and `res` connected to the granted operand, granted shamt and the register input.
- Round-robin grant logic is a local function/always block. No separate module.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles with all `req_valid`=1. Require `req_ready`=0, `resp_valid`=0 and `op_count`=0. On release, the first grant goes to requester 0.
- **Single shift:** requester 2 sends data 32'h0000_00F1 with shamt 6'd4. Next cycle requires `resp_data`=32'h0000_0F10 and `resp_id`=2. A second request with shamt 6'd32 returns 0, and shamt 6'd31 on data 1 returns 32'h8000_0000.
- **Round-robin:** all 4 requesters continuously valid with `resp_ready`=1. Require `resp_id` sequence 0,1,2,3,0,1 on consecutive cycles and `op_count`=6.
- **Backpressure:** `resp_ready`=0 for 3 cycles with requester 1 valid. Require `req_ready`=0 and stable `resp_data`/`resp_id`. Requester 1 is accepted in the cycle `resp_ready` returns to 1, with no bubble.
- **Priority hold:** block the output while grant points at 3, then release. Requester 3 is served before 0, and `last_ptr` did not advance while blocked.
- **Wrap and mid-op reset:** preload 65535 transfers, then one more gives `op_count`=0. Assert `rst_n`=0 while `resp_valid`=1; the next cycle shows `resp_valid`=0.

Source files
------------

// File: rtl/nnacc_pkg.sv
// Shared accelerator datapath widths and operand payload type.
package nnacc_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 6;
  localparam int unsigned CNT_W   = 16;

  // Operand presented to the shared shifter.
  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [SHAMT_W-1:0] shamt;
  } shift_op_t;

endpackage

// File: rtl/right_shifter.sv
// Shared scale-alignment shifter: zero-filled left shift; shamt MSB forces zero.
module right_shifter
  import nnacc_pkg::*;
(
  input  logic [DATA_W-1:0]  data,
  input  logic [SHAMT_W-1:0] shifter,
  output logic [DATA_W-1:0]  res
);

  // Out-of-range shift amounts (>= 32) flush the operand completely.
  always_comb begin
    res = '0;
    if (!shifter[SHAMT_W-1]) begin
      res = data << shifter[SHAMT_W-2:0];
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin scheduler sharing one shifter among NUM_REQ lanes, with a
// single-entry registered result stage tagged by requester ID.
module shift_arbiter
  import nnacc_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ*SHAMT_W-1:0] req_shamt,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       resp_valid,
  output logic [DATA_W-1:0]          resp_data,
  output logic [ID_W-1:0]            resp_id,
  input  logic                       resp_ready,
  output logic [CNT_W-1:0]           op_count
);

  logic [ID_W-1:0]    r_last_ptr;
  logic               r_resp_valid;
  logic [DATA_W-1:0]  r_resp_data;
  logic [ID_W-1:0]    r_resp_id;
  logic [CNT_W-1:0]   r_op_count;

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_grant_idx;
  logic               w_can_accept;
  logic               w_xfer;
  shift_op_t          w_sel_op;
  logic [DATA_W-1:0]  w_shift_res;

  // Round-robin search starting one past the last served requester.
  always_comb begin
    int unsigned v_p;
    logic        v_found;
    w_grant     = '0;
    w_grant_idx = '0;
    v_p         = 0;
    v_found     = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      v_p = (int'(r_last_ptr) + k) % NUM_REQ;
      if (!v_found && req_valid[ID_W'(v_p)]) begin
        v_found                 = 1'b1;
        w_grant[ID_W'(v_p)]     = 1'b1;
        w_grant_idx             = ID_W'(v_p);
      end
    end
  end

  // Output stage frees up when empty or being drained this cycle; nothing is
  // accepted while reset is asserted.
  always_comb begin
    w_can_accept = ~r_resp_valid | resp_ready;
    req_ready    = w_grant & {NUM_REQ{w_can_accept & rst_n}};
    w_xfer       = |(req_valid & req_ready);
  end

  // Steer the granted lane's operand into the shared shifter.
  always_comb begin
    w_sel_op = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_grant_idx == ID_W'(i)) begin
        w_sel_op.data  = req_data[i*DATA_W +: DATA_W];
        w_sel_op.shamt = req_shamt[i*SHAMT_W +: SHAMT_W];
      end
    end
  end

  right_shifter u_shifter (
    .data    (w_sel_op.data),
    .shifter (w_sel_op.shamt),
    .res     (w_shift_res)
  );

  // Result register, priority pointer and accepted-op counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_id    <= '0;
      r_op_count   <= '0;
      r_last_ptr   <= ID_W'(NUM_REQ - 1);
    end else if (w_xfer) begin
      r_resp_valid <= 1'b1;
      r_resp_data  <= w_shift_res;
      r_resp_id    <= w_grant_idx;
      r_op_count   <= r_op_count + CNT_W'(1);
      r_last_ptr   <= w_grant_idx;
    end else if (r_resp_valid && resp_ready) begin
      r_resp_valid <= 1'b0;
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_id    = r_resp_id;
  assign op_count   = r_op_count;

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed table, corner sequences and
// randomized traffic against a behavioural model.
module tb_shift_arbiter;

  localparam int NR = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR*32-1:0]  req_data;
  logic [NR*6-1:0]   req_shamt;
  logic [NR-1:0]     req_ready;
  logic              resp_valid;
  logic [31:0]       resp_data;
  logic [1:0]        resp_id;
  logic              resp_ready;
  logic [15:0]       op_count;

  shift_arbiter #(.NUM_REQ(NR), .ID_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_shamt  (req_shamt),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_ready (resp_ready),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] d_lane [NR];
  logic [5:0]  s_lane [NR];

  typedef struct {
    int          id;
    logic [31:0] data;
    logic [5:0]  shamt;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Shift expressed as multiplication by a power of two, truncated to 32 bits.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [5:0] s);
    longint unsigned p;
    longint unsigned pw;
    if (s >= 6'd32) return 32'h0;
    pw = 1;
    for (int k = 0; k < int'(s); k++) pw = pw * 2;
    p = longint'(d) * pw;
    return p[31:0];
  endfunction

  task automatic drive(input logic [NR-1:0] v, input logic rr);
    req_valid  = v;
    resp_ready = rr;
    for (int i = 0; i < NR; i++) begin
      req_data[i*32 +: 32] = d_lane[i];
      req_shamt[i*6 +: 6]  = s_lane[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Model state
  int          m_last;
  bit          m_valid;
  logic [31:0] m_data;
  int          m_id;
  int          m_count;

  initial begin
    tbl[0] = '{2, 32'h0000_00F1, 6'd4,  32'h0000_0F10};
    tbl[1] = '{2, 32'h1234_5678, 6'd32, 32'h0000_0000};
    tbl[2] = '{0, 32'h0000_0001, 6'd31, 32'h8000_0000};
    tbl[3] = '{1, 32'hDEAD_BEEF, 6'd0,  32'hDEAD_BEEF};
    tbl[4] = '{3, 32'hFFFF_FFFF, 6'd63, 32'h0000_0000};
    tbl[5] = '{3, 32'h0000_FFFF, 6'd16, 32'hFFFF_0000};

    for (int i = 0; i < NR; i++) begin
      d_lane[i] = 32'h0;
      s_lane[i] = 6'h0;
    end

    // Reset held two cycles with all lanes requesting
    rst_n = 1'b0;
    drive(4'hF, 1'b1);
    for (int c = 0; c < 2; c++) begin
      #4;
      chk("reset_req_ready", 32'(req_ready), 32'h0);
      tick();
      chk("reset_resp_valid", 32'(resp_valid), 32'h0);
      chk("reset_op_count", 32'(op_count), 32'h0);
      chk("reset_resp_data", resp_data, 32'h0);
    end
    rst_n = 1'b1;
    #4;
    chk("first_grant", 32'(req_ready), 32'h1);
    tick();
    chk("first_grant_id", 32'(resp_id), 32'h0);

    // Directed single-lane shifts
    for (int t = 0; t < 6; t++) begin
      d_lane[tbl[t].id] = tbl[t].data;
      s_lane[tbl[t].id] = tbl[t].shamt;
      drive(4'(1 << tbl[t].id), 1'b1);
      #4;
      chk($sformatf("vec%0d_ready", t), 32'(req_ready), 32'(1 << tbl[t].id));
      tick();
      chk($sformatf("vec%0d_data", t), resp_data, tbl[t].exp);
      chk($sformatf("vec%0d_id", t), 32'(resp_id), 32'(tbl[t].id));
      chk($sformatf("vec%0d_valid", t), 32'(resp_valid), 32'h1);
    end

    // Round-robin with all lanes valid
    drive(4'h0, 1'b1);
    do_reset();
    for (int i = 0; i < NR; i++) begin
      d_lane[i] = 32'h10 + 32'(i);
      s_lane[i] = 6'(i);
    end
    drive(4'hF, 1'b1);
    for (int c = 0; c < 6; c++) begin
      #4;
      chk("rr_ready", 32'(req_ready), 32'(1 << (c % NR)));
      tick();
      chk("rr_id", 32'(resp_id), 32'(c % NR));
      chk("rr_data", resp_data, ref_shift(d_lane[c % NR], s_lane[c % NR]));
    end
    chk("rr_op_count", 32'(op_count), 32'd6);

    // Backpressure on requester 1
    d_lane[1] = 32'h0000_ABCD;
    s_lane[1] = 6'd8;
    drive(4'b0010, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #4;
      chk("bp_ready", 32'(req_ready), 32'h0);
      tick();
      chk("bp_hold_data", resp_data, ref_shift(32'h11, 6'd1));
      chk("bp_hold_id", 32'(resp_id), 32'h1);
      chk("bp_hold_valid", 32'(resp_valid), 32'h1);
    end
    resp_ready = 1'b1;
    #4;
    chk("bp_release_ready", 32'(req_ready), 32'b0010);
    tick();
    chk("bp_release_data", resp_data, 32'h00AB_CD00);
    chk("bp_release_valid", 32'(resp_valid), 32'h1);
    chk("bp_op_count", 32'(op_count), 32'd7);

    // Priority hold: grant points at 3 while output blocked
    drive(4'b0100, 1'b1);
    tick();
    chk("ph_pre_id", 32'(resp_id), 32'h2);
    drive(4'b1001, 1'b0);
    for (int c = 0; c < 2; c++) begin
      #4;
      chk("ph_blocked_ready", 32'(req_ready), 32'h0);
      tick();
    end
    resp_ready = 1'b1;
    #4;
    chk("ph_ready3", 32'(req_ready), 32'b1000);
    tick();
    chk("ph_id3", 32'(resp_id), 32'h3);
    #4;
    chk("ph_ready0", 32'(req_ready), 32'b0001);
    tick();
    chk("ph_id0", 32'(resp_id), 32'h0);
    chk("ph_op_count", 32'(op_count), 32'd10);

    // Randomized traffic against the model
    drive(4'h0, 1'b1);
    do_reset();
    m_last = NR - 1; m_valid = 0; m_data = 0; m_id = 0; m_count = 0;
    for (int it = 0; it < 400; it++) begin
      logic [NR-1:0] rv;
      logic          rr;
      bit            can;
      int            win;
      int            best;
      logic [NR-1:0] exp_ready;
      rv = NR'($urandom_range(0, 15));
      rr = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NR; i++) begin
        d_lane[i] = $urandom;
        s_lane[i] = ($urandom_range(0, 7) == 0) ? 6'(32 + $urandom_range(0, 31))
                                                : 6'($urandom_range(0, 31));
      end
      drive(rv, rr);
      can  = !m_valid || rr;
      win  = -1;
      best = NR;
      for (int i = 0; i < NR; i++) begin
        int d;
        d = (i - m_last - 1 + 2 * NR) % NR;
        if (rv[i] && d < best) begin
          best = d;
          win  = i;
        end
      end
      exp_ready = (can && win >= 0) ? NR'(1 << win) : '0;
      #4;
      chk("rnd_ready", 32'(req_ready), 32'(exp_ready));
      if (exp_ready != 0) begin
        m_data  = ref_shift(d_lane[win], s_lane[win]);
        m_id    = win;
        m_valid = 1;
        m_last  = win;
        m_count = (m_count + 1) % 65536;
      end else if (rr && m_valid) begin
        m_valid = 0;
      end
      tick();
      chk("rnd_valid", 32'(resp_valid), 32'(m_valid));
      chk("rnd_data", resp_data, m_data);
      chk("rnd_id", 32'(resp_id), 32'(m_id));
      chk("rnd_count", 32'(op_count), 32'(m_count));
    end

    // Counter wrap, then reset while a result is pending
    drive(4'h0, 1'b1);
    do_reset();
    drive(4'hF, 1'b1);
    repeat (65535) tick();
    chk("wrap_ffff", 32'(op_count), 32'hFFFF);
    tick();
    chk("wrap_zero", 32'(op_count), 32'h0);
    chk("wrap_valid", 32'(resp_valid), 32'h1);
    rst_n = 1'b0;
    #4;
    chk("midrst_ready", 32'(req_ready), 32'h0);
    tick();
    chk("midrst_valid", 32'(resp_valid), 32'h0);
    chk("midrst_data", resp_data, 32'h0);
    chk("midrst_count", 32'(op_count), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
